// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// The optional timeout (MULT_ARB_TIMEOUT_EN) uses TIMEOUT_CYC and TMO_CNT_W.
package mult_arb_pkg;
    localparam int OP_W        = 32;
    localparam int PROD_W      = 64;
    localparam int TIMEOUT_CYC = 12;
    localparam int TMO_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/multiplier_iterative.sv
// Iterative 32x32->64 unsigned multiplier, one nibble of a per cycle.
// No reset: valid_out is a level that stays high until the next start.
module multiplier_iterative (
    input  logic        clk,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [63:0] r
);
    logic [31:0] a_rem;
    logic [63:0] b_sh;
    logic        busy;

    always_ff @(posedge clk) begin
        if (valid_in) begin
            // The start edge already consumes the lowest nibble.
            r         <= 64'(a[3:0]) * 64'(b);
            a_rem     <= a >> 4;
            b_sh      <= {28'd0, b, 4'd0};
            busy      <= (a >> 4) != 32'd0;
            valid_out <= (a >> 4) == 32'd0;
        end else if (busy) begin
            r         <= r + 64'(a_rem[3:0]) * b_sh;
            a_rem     <= a_rem >> 4;
            b_sh      <= b_sh << 4;
            busy      <= (a_rem >> 4) != 32'd0;
            valid_out <= (a_rem >> 4) == 32'd0;
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above ptr,
// wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             grant_valid
);
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                grant       = ID_W'((int'(ptr) + k) % N_REQ);
                grant_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one iterative multiplier among N_REQ requesters.
// Optional timeout on the multiplier done flag: define MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*OP_W-1:0] req_a,
    input  logic [N_REQ*OP_W-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [PROD_W-1:0]     resp_r,
    output logic                  resp_err,
    output logic                  mul_valid_in,
    output logic [OP_W-1:0]       mul_a,
    output logic [OP_W-1:0]       mul_b,
    input  logic                  mul_valid_out,
    input  logic [PROD_W-1:0]     mul_r
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds valid and data stable until that edge.
    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_next;
    logic [ID_W-1:0] grant;
    logic            grant_valid;
    logic            accept;
    logic            done_seen;
    logic            tmo_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign accept       = (state_q == IDLE) && grant_valid;
    assign done_seen    = (state_q == WAIT) && mul_valid_out;
    assign ptr_next     = (int'(grant) == N_REQ - 1) ? '0 : grant + ID_W'(1);
    assign mul_valid_in = (state_q == ISSUE);
    assign resp_valid   = (state_q == RESP);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done_seen || tmo_hit) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            resp_id <= '0;
            resp_r  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mul_a   <= req_a[int'(grant)*OP_W +: OP_W];
                mul_b   <= req_b[int'(grant)*OP_W +: OP_W];
                resp_id <= grant;
                ptr_q   <= ptr_next;
            end
            if (done_seen) begin
                resp_r <= mul_r;
            end else if (tmo_hit) begin
                resp_r <= '0;
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt_q;

    // Cleared while issuing, so the first WAIT cycle sees zero.
    assign tmo_hit = (state_q == WAIT) && !mul_valid_out &&
                     (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            resp_err  <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                tmo_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_CNT_W'(1);
            end
            if (done_seen) begin
                resp_err <= 1'b0;
            end else if (tmo_hit) begin
                resp_err <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter driving a multiplier_iterative instance.
// Timeout scenario is compiled in with MULT_ARB_TIMEOUT_EN.
module tb_mult_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic         resp_valid, resp_ready;
    logic [1:0]   resp_id;
    logic [63:0]  resp_r;
    logic         resp_err;
    logic         mul_valid_in;
    logic [31:0]  mul_a, mul_b;
    logic         mul_done, mul_valid_out;
    logic [63:0]  mul_r;
    logic         hang;

    int vectors = 0;
    int errors  = 0;
    logic [63:0] exp_q[$];

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // hang models a multiplier that never reports completion
    assign mul_valid_out = mul_done & ~hang;

    mult_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_r        (resp_r),
        .resp_err      (resp_err),
        .mul_valid_in  (mul_valid_in),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid_out (mul_valid_out),
        .mul_r         (mul_r)
    );

    multiplier_iterative u_mul (
        .clk       (clk),
        .valid_in  (mul_valid_in),
        .a         (mul_a),
        .b         (mul_b),
        .valid_out (mul_done),
        .r         (mul_r)
    );

    // Driver tasks
    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output logic [3:0] rdy, output int gid, output bit ok);
        ok  = 1'b0;
        rdy = '0;
        gid = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready != 4'b0000) begin
                rdy = req_ready;
                for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_resp(output logic [1:0] id, output logic [63:0] r,
                             output logic err, output bit ok);
        ok  = 1'b0;
        id  = '0;
        r   = '0;
        err = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (resp_valid) begin
                id  = resp_id;
                r   = resp_r;
                err = resp_err;
                resp_ready = 1'b1;
                @(posedge clk);
                #1 resp_ready = 1'b0;
                ok = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Single request from an idle arbiter: latency counts cycles after the accept edge.
    task automatic run_one(input int i, input logic [31:0] a, input logic [31:0] b,
                           output logic [3:0] rdy, output logic [1:0] id,
                           output logic [63:0] r, output logic err,
                           output int lat, output int pulses, output bit ok);
        ok = 1'b0; lat = 0; pulses = 0; id = '0; r = '0; err = 1'b0;
        set_req(i, a, b);
        #1 rdy = req_ready;
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            lat = c;
            if (mul_valid_in) pulses++;
            if (resp_valid) begin
                id = resp_id; r = resp_r; err = resp_err; ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
        end
    endtask

    // Scenario tasks
    task automatic test_reset();
        #1;
        vectors++;
        if (req_ready !== 4'b0 || resp_valid !== 1'b0 || mul_valid_in !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got ready=%b rv=%b mvi=%b want 0000/0/0",
                     req_ready, resp_valid, mul_valid_in);
        end
        vectors++;
        if (resp_id !== 2'd0 || resp_r !== 64'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp got id=%0d r=%h err=%b want 0/0/0", resp_id, resp_r, resp_err);
        end
        vectors++;
        if (mul_a !== 32'd0 || mul_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_ops got a=%h b=%h want 0/0", mul_a, mul_b);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [3:0] rdy; logic [1:0] id; logic [63:0] r; logic err;
        int lat, pulses; bit ok;
        run_one(0, 32'd7, 32'd6, rdy, id, r, err, lat, pulses, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL single_resp got no response want one"); end
        vectors++;
        if (rdy !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", rdy); end
        vectors++;
        if (id !== 2'd0 || r !== 64'd42 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_data got id=%0d r=%0d err=%b want 0/42/0", id, r, err);
        end
        vectors++;
        if (pulses != 1) begin errors++; $display("FAIL single_pulse got %0d want 1", pulses); end
        vectors++;
        if (lat != 3) begin errors++; $display("FAIL single_latency got %0d want 3", lat); end
        vectors++;
        if (mul_a !== 32'd7 || mul_b !== 32'd6 || mul_valid_in !== 1'b0) begin
            errors++;
            $display("FAIL single_hold got a=%0d b=%0d mvi=%b want 7/6/0", mul_a, mul_b, mul_valid_in);
        end
    endtask

    task automatic serve(input int n, input int exp_ids[4], input string tag);
        logic [3:0] rdy; logic [1:0] id; logic [63:0] r; logic [63:0] exp_r; logic err;
        int gid; bit ok;
        for (int k = 0; k < n; k++) begin
            wait_grant(rdy, gid, ok);
            exp_r = exp_q.pop_front();
            vectors++;
            if (!ok || rdy !== (4'b0001 << exp_ids[k])) begin
                errors++;
                $display("FAIL %s_grant%0d got %b want one-hot id %0d", tag, k, rdy, exp_ids[k]);
            end
            if (!ok) return;
            @(posedge clk);
            #1 req_valid[gid] = 1'b0;
            wait_resp(id, r, err, ok);
            vectors++;
            if (!ok || id !== 2'(exp_ids[k]) || r !== exp_r) begin
                errors++;
                $display("FAIL %s_resp%0d got ok=%b id=%0d r=%0d want id=%0d r=%0d",
                         tag, k, ok, id, r, exp_ids[k], exp_r);
            end
        end
    endtask

    task automatic test_contention();
        int ids_a[4] = '{0, 1, 2, 3};
        int ids_b[4] = '{1, 3, 0, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(i + 1);
            req_b[i*32 +: 32] = 32'd10;
            exp_q.push_back(64'((i + 1) * 10));
        end
        req_valid = 4'b1111;
        serve(4, ids_a, "contend");
        set_req(1, 32'd2, 32'd10);
        set_req(3, 32'd4, 32'd10);
        exp_q.push_back(64'd20);
        exp_q.push_back(64'd40);
        serve(2, ids_b, "rerequest");
    endtask

    task automatic test_zero_max();
        logic [3:0] rdy; logic [1:0] id; logic [63:0] r; logic err;
        int lat, pulses; bit ok;
        run_one(0, 32'd0, 32'hFFFF_FFFF, rdy, id, r, err, lat, pulses, ok);
        vectors++;
        if (!ok || r !== 64'd0 || lat != 3) begin
            errors++;
            $display("FAIL zero_a got ok=%b r=%h lat=%0d want r=0 lat=3", ok, r, lat);
        end
        run_one(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy, id, r, err, lat, pulses, ok);
        vectors++;
        if (!ok || r !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL max_ab got ok=%b r=%h want fffffffe00000001", ok, r);
        end
        vectors++;
        if (lat != 10) begin errors++; $display("FAIL max_latency got %0d want 10", lat); end
    endtask

    task automatic test_back_pressure();
        logic [3:0] rdy; logic [1:0] id; logic [63:0] r; logic err;
        int gid; bit ok;
        set_req(2, 32'd9, 32'd9);
        wait_grant(rdy, gid, ok);
        vectors++;
        if (!ok || rdy !== 4'b0100) begin
            errors++;
            $display("FAIL bp_grant got %b want 0100", rdy);
        end
        @(posedge clk);
        #1 req_valid[2] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (resp_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!ok) begin errors++; $display("FAIL bp_resp got no resp_valid want one"); end
        set_req(0, 32'd11, 32'd3);
        for (int c = 0; c < 10; c++) begin
            #1;
            vectors++;
            if ({resp_valid, resp_id, resp_r, req_ready} !== {1'b1, 2'd2, 64'd81, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold%0d got rv=%b id=%0d r=%0d rdy=%b want 1/2/81/0000",
                         c, resp_valid, resp_id, resp_r, req_ready);
            end
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 4'b0001 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_next got rdy=%b rv=%b want 0001/0", req_ready, resp_valid);
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_resp(id, r, err, ok);
        vectors++;
        if (!ok || id !== 2'd0 || r !== 64'd33) begin
            errors++;
            $display("FAIL bp_next_resp got ok=%b id=%0d r=%0d want 0/33", ok, id, r);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] rdy; logic [1:0] id; logic [63:0] r; logic err;
        int lat, pulses, gid; bit ok, quiet;
        set_req(1, 32'hFFFF_FFFF, 32'd3);
        wait_grant(rdy, gid, ok);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (resp_valid !== 1'b0 || mul_valid_in !== 1'b0 || resp_r !== 64'd0 || resp_id !== 2'd0) begin
            errors++;
            $display("FAIL midrst_clear got rv=%b mvi=%b r=%h id=%0d want 0/0/0/0",
                     resp_valid, mul_valid_in, resp_r, resp_id);
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mul_done) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!ok) begin errors++; $display("FAIL midrst_stale got done=0 want stale done=1"); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b0 || mul_valid_in !== 1'b0) quiet = 1'b0;
        end
        vectors++;
        if (!quiet) begin errors++; $display("FAIL midrst_quiet got spurious activity want none"); end
        run_one(2, 32'd3, 32'd5, rdy, id, r, err, lat, pulses, ok);
        vectors++;
        if (!ok || id !== 2'd2 || r !== 64'd15 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_new got ok=%b id=%0d r=%0d err=%b want 2/15/0", ok, id, r, err);
        end
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] rdy; logic [1:0] id; logic [63:0] r; logic err;
        int lat, pulses, gid, cyc; bit ok;
        hang = 1'b1;
        set_req(3, 32'd4, 32'd4);
        wait_grant(rdy, gid, ok);
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        cyc = 0;
        ok  = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin cyc = c; ok = 1'b1; break; end
        end
        // cycle 0 is ISSUE, cycles 1..12 are WAIT
        vectors++;
        if (!ok || cyc != 13) begin
            errors++;
            $display("FAIL timeout_cycles got %0d want 13", cyc);
        end
        vectors++;
        if (resp_err !== 1'b1 || resp_r !== 64'd0 || resp_id !== 2'd3) begin
            errors++;
            $display("FAIL timeout_resp got err=%b r=%h id=%0d want 1/0/3", resp_err, resp_r, resp_id);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        hang = 1'b0;
        run_one(0, 32'd5, 32'd5, rdy, id, r, err, lat, pulses, ok);
        vectors++;
        if (!ok || r !== 64'd25 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover got ok=%b r=%0d err=%b want 25/0", ok, r, err);
        end
    endtask
`endif

    initial begin
        hang       = 1'b0;
        rst_n      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        #2 rst_n = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_zero_max();
        test_back_pressure();
        test_reset_mid();
`ifdef MULT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one iterative 32x32->64 multiplier between N_REQ requesters.
- Each requester has a valid/ready request channel. All requesters share one response channel, tagged with the requester ID.
- The block owns the multiplier's start pulse and operand registers, waits for the multiplier's completion flag, and returns the product.
- Fairness is round-robin. Exactly one multiplication is in flight at a time.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester tag, equals clog2(N_REQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_a  in  N_REQ*32  packed multiplicands, slice i belongs to requester i
req_b  in  N_REQ*32  packed multipliers
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  ID_W  requester tag of result
resp_r  out  64  unsigned product
resp_err  out  1  timeout flag (only driven when MULT_ARB_TIMEOUT_EN is defined)
mul_valid_in  out  1  one-cycle start pulse to the multiplier
mul_a  out  32  operand a to the multiplier
mul_b  out  32  operand b to the multiplier
mul_valid_out  in  1  multiplier done flag; level, stays high after completion
mul_r  in  64  multiplier product

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and the round-robin pointer goes to 0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_r=0, resp_err=0.
  - mul_valid_in=0, mul_a=0, mul_b=0.
- IDLE:
  - Requests are considered only in IDLE.
  - grant = first i with req_valid[i]=1, searching from pointer upward with wrap (N_REQ-1 -> 0).
  - req_ready[grant]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the edge, latch req_a/req_b slices into mul_a/mul_b, latch grant into resp_id, set pointer=(grant+1) mod N_REQ, and go to ISSUE.
  - If no req_valid bit is set, stay in IDLE.
- ISSUE:
  - mul_valid_in=1 for exactly this one cycle.
  - mul_valid_out is ignored here because it may still be high from a previous operation.
  - Go to WAIT.
- WAIT:
  - The multiplier drops valid_out on the edge after the start pulse.
  - Capture mul_r into resp_r on the first cycle with mul_valid_out=1, then go to RESP.
  - Multiplier latency is 1..8 cycles after the start edge. It is data-dependent: a=0 completes after 1 iteration.
- RESP:
  - resp_valid=1; resp_id, resp_r and resp_err are held stable until resp_ready=1.
  - When resp_valid=1 and resp_ready=1 on the same edge, go to IDLE.
  - resp_ready is ignored when resp_valid=0.
- Throughput and latency:
  - Minimum request-to-response latency is 3 cycles (IDLE accept, ISSUE, WAIT with 1 iteration).
  - At most one request is accepted per 4 cycles; no back-to-back acceptance in RESP.
- Boundary conditions:
  - Simultaneous requests: only one is granted. Ungranted requesters must hold valid and data.
  - Pointer wrap: grant N_REQ-1 sets pointer to 0.
  - A requester dropping req_valid without req_ready is legal and gets no grant.
  - mul_a, mul_b and mul_valid_in hold their values outside ISSUE; only mul_valid_in is forced low.
  - Reset mid-operation: the multiplier has no reset and may hold stale state. Because the controller ignores mul_valid_out in IDLE and ISSUE, a stale done flag can never produce a response.
- Arithmetic:
  - Unsigned only; the 64-bit product is passed through unmodified.

Optional Feature:
- MULT_ARB_TIMEOUT_EN defined:
  - A 4-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches 12 without mul_valid_out, go to RESP with resp_err=1 and resp_r=0.
  - resp_err=0 for normal completions.
- MULT_ARB_TIMEOUT_EN not defined: no counter is built, resp_err is tied to 0, and WAIT waits indefinitely.

Decomposition:
- Package mult_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - constants OP_W=32, PROD_W=64, TIMEOUT_CYC=12.
- One natural sub-module, rr_arbiter: combinational round-robin pick.
  - Inputs: req vector and pointer.
  - Outputs: grant index and grant_valid.
- The FSM and registers stay in mult_arbiter.
- The bench instantiates multiplier_iterative alongside mult_arbiter.

Test Plan:
1. Single request: req 0, a=7, b=6 -> resp_valid with resp_id=0, resp_r=42. mul_valid_in is high exactly one cycle.
2. Contention: all 4 requesters valid, a=i+1, b=10 -> responses in ID order 0,1,2,3 with r=10,20,30,40. Then re-request 1 and 3 only -> order 3 is not granted first: 1 then 3 (pointer was 0).
3. Zero and max operands: a=0, b=0xFFFFFFFF -> r=0 with 3-cycle latency. a=b=0xFFFFFFFF -> r=0xFFFFFFFE00000001.
4. Back-pressure: resp_ready held 0 for 10 cycles -> resp_valid, resp_id and resp_r are stable and req_ready stays 0. resp_ready=1 -> accepted, and the next request is granted in IDLE.
5. Reset mid-WAIT: rst_n low while the multiplier is busy, released with mul_valid_out stale high -> no response until a new request. A new request a=3, b=5 yields r=15.
6. (MULT_ARB_TIMEOUT_EN) Bench model holds mul_valid_out=0 -> after 12 WAIT cycles, resp_valid=1, resp_err=1, resp_r=0.
